msx_cart_bus_bridge: RTL and testbench

//  Parametrised bridge from the asynchronous MSX cartridge strobes (n_ce/n_trd/n_twr, ta, td) to the

---
 rtl/msx_cart_bus_bridge.sv | 164 ++++++++++++++++
 tb/tb_msx_cart_bus_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/msx_cart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : msx_cart_bus_bridge
// Brief    : Bridges the asynchronous MSX cartridge strobes to the internal
//            single-clock req/ack device bus. Synchronises and filters the
//            strobes, stretches the Z80 cycle with twait until the device
//            acknowledges or a timeout fires, and drives td for reads.
// Revision : 1.0 - initial release
// ============================================================================
module msx_cart_bus_bridge #(
  parameter int ADDR_W       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n_ce,
  input  logic              n_trd,
  input  logic              n_twr,
  input  logic [ADDR_W-1:0] ta,
  input  logic [7:0]        td_in,
  output logic [7:0]        td_out,
  output logic              tdir,
  output logic              twait,
  output logic              req,
  input  logic              ack,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  output logic              timeout
);

  localparam int         c_FW       = $clog2(FILTER_LEN + 1);
  localparam logic [c_FW-1:0] c_FILT_DONE = c_FW'(FILTER_LEN);
  localparam logic [7:0] c_TO_LAST  = 8'(WAIT_TIMEOUT - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [SYNC_STAGES-1:0] r_trd_sync;
  logic [SYNC_STAGES-1:0] r_twr_sync;
  // Tracks how far real pin samples have travelled through the chain; the
  // chain's reset value of 1 must not be mistaken for released strobes.
  logic [SYNC_STAGES-1:0] r_flush;

  logic [1:0]      r_state;
  logic            r_armed;
  logic [c_FW-1:0] r_filt;
  logic [7:0]      r_to_cnt;

  logic w_ce;
  logic w_trd;
  logic w_twr;
  logic w_valid;
  logic w_all_high;
  logic w_start_cond;

  assign w_ce         = r_ce_sync[SYNC_STAGES-1];
  assign w_trd        = r_trd_sync[SYNC_STAGES-1];
  assign w_twr        = r_twr_sync[SYNC_STAGES-1];
  assign w_valid      = r_flush[SYNC_STAGES-1];
  assign w_all_high   = w_ce & w_trd & w_twr;
  assign w_start_cond = r_armed & ~w_ce & (~w_trd | ~w_twr);

  // Multi-stage synchronisers for the asynchronous strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ce_sync  <= '1;
      r_trd_sync <= '1;
      r_twr_sync <= '1;
      r_flush    <= '0;
    end else begin
      r_ce_sync  <= {r_ce_sync[SYNC_STAGES-2:0], n_ce};
      r_trd_sync <= {r_trd_sync[SYNC_STAGES-2:0], n_trd};
      r_twr_sync <= {r_twr_sync[SYNC_STAGES-2:0], n_twr};
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Access state machine: qualify, request, wait for ack/timeout, hold td
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_armed  <= 1'b0;
      r_filt   <= '0;
      r_to_cnt <= '0;
      td_out   <= 8'hFF;
      tdir     <= 1'b0;
      twait    <= 1'b0;
      req      <= 1'b0;
      wr       <= 1'b0;
      address  <= '0;
      wdata    <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // A strobe stuck low since reset must be released before any access
      if (!r_armed && w_valid && w_all_high) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_start_cond) begin
            if (r_filt == c_FILT_DONE) begin
              r_state  <= c_REQ;
              address  <= ta;
              wr       <= ~w_twr;
              if (!w_twr) begin
                wdata <= td_in;
              end
              req      <= 1'b1;
              twait    <= 1'b1;
              r_to_cnt <= '0;
              r_filt   <= '0;
            end else begin
              r_filt <= r_filt + 1'b1;
            end
          end else begin
            r_filt <= '0;
          end
        end
        c_REQ: begin
          // ack has priority over a timeout landing in the same cycle
          if (ack) begin
            req     <= 1'b0;
            twait   <= 1'b0;
            if (!wr) begin
              td_out <= rdata;
            end
            r_state <= c_HOLD;
          end else if (r_to_cnt == c_TO_LAST) begin
            req     <= 1'b0;
            twait   <= 1'b0;
            td_out  <= 8'hFF;
            timeout <= 1'b1;
            r_state <= c_HOLD;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        c_HOLD: begin
          if (w_all_high) begin
            tdir    <= 1'b0;
            r_state <= c_IDLE;
          end else begin
            tdir <= ~wr & ~w_ce & ~w_trd;
          end
        end
        default: begin
          r_state <= c_IDLE;
          tdir    <= 1'b0;
          req     <= 1'b0;
          twait   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_cart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_msx_cart_bus_bridge
// Brief    : Directed bench for msx_cart_bus_bridge with a transaction
//            scoreboard for the latched request fields.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_cart_bus_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       n_ce, n_trd, n_twr;
  logic [1:0] ta;
  logic [7:0] td_in;
  logic [7:0] td_out;
  logic       tdir, twait, req, ack, wr, timeout;
  logic [1:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  msx_cart_bus_bridge #(
    .ADDR_W      (2),
    .SYNC_STAGES (2),
    .FILTER_LEN  (2),
    .WAIT_TIMEOUT(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .n_ce   (n_ce),
    .n_trd  (n_trd),
    .n_twr  (n_twr),
    .ta     (ta),
    .td_in  (td_in),
    .td_out (td_out),
    .tdir   (tdir),
    .twait  (twait),
    .req    (req),
    .ack    (ack),
    .wr     (wr),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for req, then pop the scoreboard and compare latched fields
  task automatic expect_req(input string tag);
    int   k = 0;
    txn_t t;
    while (req !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk({tag, "_req"}, 32'(req), 32'd1);
    chk({tag, "_twait"}, 32'(twait), 32'd1);
    chk({tag, "_qdepth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      chk({tag, "_wr"}, 32'(wr), 32'(t.wr));
      chk({tag, "_addr"}, 32'(address), 32'(t.addr));
      if (t.wr) chk({tag, "_wdata"}, 32'(wdata), 32'(t.wdata));
    end
  endtask

  task automatic release_bus();
    n_ce = 1'b1; n_trd = 1'b1; n_twr = 1'b1;
    step(4);
  endtask

  initial begin
    reset = 1'b1; n_ce = 1'b1; n_trd = 1'b1; n_twr = 1'b1;
    ta = '0; td_in = '0; ack = 1'b0; rdata = '0;
    step(3);
    chk("rst_td_out", 32'(td_out), 32'hFF);
    chk("rst_tdir", 32'(tdir), 32'd0);
    chk("rst_twait", 32'(twait), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    step(4);

    // Read at ta=1, ack five cycles after req with 8'hA5
    ta = 2'b01; n_ce = 1'b0; n_trd = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 2'b01, wdata: 8'h00});
    step(4);
    chk("rd_latency_early", 32'(req), 32'd0);
    step(1);
    expect_req("rd");
    step(4);
    chk("rd_req_held", 32'(req), 32'd1);
    chk("rd_tdir_in_req", 32'(tdir), 32'd0);
    ack = 1'b1; rdata = 8'hA5;
    step(1);
    ack = 1'b0; rdata = 8'h00;
    chk("rd_req_drop", 32'(req), 32'd0);
    chk("rd_twait_drop", 32'(twait), 32'd0);
    chk("rd_td_out", 32'(td_out), 32'hA5);
    step(1);
    chk("rd_tdir_on", 32'(tdir), 32'd1);
    n_ce = 1'b1; n_trd = 1'b1;
    step(2);
    chk("rd_tdir_still", 32'(tdir), 32'd1);
    step(1);
    chk("rd_tdir_off", 32'(tdir), 32'd0);
    step(2);

    // Write at ta=3 with 8'h3C
    ta = 2'b11; td_in = 8'h3C; n_ce = 1'b0; n_twr = 1'b0;
    exp_q.push_back('{wr: 1'b1, addr: 2'b11, wdata: 8'h3C});
    expect_req("wr");
    chk("wr_tdir_req", 32'(tdir), 32'd0);
    step(2);
    ack = 1'b1; rdata = 8'h11;
    step(1);
    ack = 1'b0;
    chk("wr_twait_drop", 32'(twait), 32'd0);
    chk("wr_req_drop", 32'(req), 32'd0);
    chk("wr_td_out_kept", 32'(td_out), 32'hA5);
    step(2);
    chk("wr_tdir_hold", 32'(tdir), 32'd0);
    td_in = 8'h00;
    release_bus();

    // ack while idle must not touch td_out
    ack = 1'b1; rdata = 8'h77;
    step(1);
    ack = 1'b0;
    step(1);
    chk("idle_ack_ignored", 32'(td_out), 32'hA5);
    chk("idle_ack_no_req", 32'(req), 32'd0);

    // One-cycle glitch on n_ce with n_trd low
    n_trd = 1'b0;
    step(2);
    n_ce = 1'b0;
    step(1);
    n_ce = 1'b1;
    step(8);
    chk("glitch_req", 32'(req), 32'd0);
    chk("glitch_twait", 32'(twait), 32'd0);
    release_bus();

    // Read with no ack: forced release after 8 REQ cycles
    ta = 2'b10; n_ce = 1'b0; n_trd = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 2'b10, wdata: 8'h00});
    expect_req("to");
    step(7);
    chk("to_req_7", 32'(req), 32'd1);
    chk("to_pulse_early", 32'(timeout), 32'd0);
    step(1);
    chk("to_req_drop", 32'(req), 32'd0);
    chk("to_twait_drop", 32'(twait), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_td_out", 32'(td_out), 32'hFF);
    step(1);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_tdir", 32'(tdir), 32'd1);
    release_bus();

    // ack lands in the exact timeout cycle
    ta = 2'b00; n_ce = 1'b0; n_trd = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 2'b00, wdata: 8'h00});
    expect_req("race");
    step(7);
    ack = 1'b1; rdata = 8'h5A;
    step(1);
    ack = 1'b0;
    chk("race_timeout", 32'(timeout), 32'd0);
    chk("race_td_out", 32'(td_out), 32'h5A);
    chk("race_req", 32'(req), 32'd0);
    step(1);
    chk("race_timeout_after", 32'(timeout), 32'd0);
    release_bus();

    // Reset pulsed in REQ with n_trd held low, ack pending
    ta = 2'b11; n_ce = 1'b0; n_trd = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 2'b11, wdata: 8'h00});
    expect_req("mid");
    reset = 1'b1; ack = 1'b1; rdata = 8'h99;
    step(1);
    ack = 1'b0;
    chk("mid_req", 32'(req), 32'd0);
    chk("mid_twait", 32'(twait), 32'd0);
    chk("mid_td_out", 32'(td_out), 32'hFF);
    chk("mid_tdir", 32'(tdir), 32'd0);
    chk("mid_addr", 32'(address), 32'd0);
    reset = 1'b0;
    step(12);
    chk("mid_no_req", 32'(req), 32'd0);
    chk("mid_no_twait", 32'(twait), 32'd0);
    chk("mid_td_out_kept", 32'(td_out), 32'hFF);
    release_bus();
    ta = 2'b01; n_ce = 1'b0; n_trd = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 2'b01, wdata: 8'h00});
    expect_req("rearm");
    step(2);
    ack = 1'b1; rdata = 8'hC3;
    step(1);
    ack = 1'b0;
    chk("rearm_td_out", 32'(td_out), 32'hC3);
    release_bus();
    chk("end_tdir", 32'(tdir), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
